flash_read_sequencer: RTL and testbench

Upstream master for the Flash address decoder: it accepts a block-read request (start address and byte count), drives the 16-bit address bus one byte at a time, waits a fixed number of cycles for Flash access, captures the returned byte and delivers it over a valid/ready stream. It also rejects addresses outside the mapped Flash window (0x0000–0x3FFF), so the decoder never sees an unmapped address during a transfer.

---
 rtl/flash_map_pkg.sv | 16 +
 rtl/access_wait_timer.sv | 22 ++
 rtl/flash_read_sequencer.sv | 117 +++++++++++
 tb/tb_flash_read_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/flash_map_pkg.sv
// Flash address map and sequencer state encoding shared by the read
// sequencer and the downstream address decoder.
package flash_map_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT,
    S_HOLD,
    S_FINISH
  } seq_state_t;

  localparam logic [15:0] FLASH0_BASE      = 16'h0000;
  localparam logic [15:0] FLASH1_BASE      = 16'h2000;
  localparam logic [15:0] ADDR_LIMIT       = 16'h3FFF;
  localparam int          WAIT_CYCLES_DEF  = 3;
endpackage

// File: rtl/access_wait_timer.sv
// Loadable down-counter timing the Flash access window; o_zero marks the
// final access cycle.
module access_wait_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  output logic          o_zero
);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_dec)  r_cnt <= r_cnt - CW'(1);
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/flash_read_sequencer.sv
// Block-read master for the Flash decoder: walks an address range one byte
// at a time, waits out the access time, and streams bytes over valid/ready.
module flash_read_sequencer #(
  parameter int           N           = 16,
  parameter int           LEN_W       = 8,
  parameter int           WAIT_CYCLES = flash_map_pkg::WAIT_CYCLES_DEF,
  parameter logic [N-1:0] ADDR_LIMIT  = N'(flash_map_pkg::ADDR_LIMIT)
) (
  input  logic             clk,
  input  logic             nRESET,
  input  logic             start,
  input  logic [N-1:0]     start_addr,
  input  logic [LEN_W-1:0] length,
  input  logic [7:0]       flash_data,
  input  logic             out_ready,
  output logic [N-1:0]     address,
  output logic             busy,
  output logic [7:0]       data_out,
  output logic             data_valid,
  output logic             done,
  output logic             range_err
);
  import flash_map_pkg::*;

  localparam int           CW        = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES - 1);

  seq_state_t       r_state;
  logic [N-1:0]     r_addr;
  logic [LEN_W-1:0] r_remain;
  logic [7:0]       r_data;
  logic             r_valid, r_busy, r_done, r_err;
  logic [N-1:0]     w_addr_inc;
  logic             w_zero;

  assign w_addr_inc = r_addr + N'(1);

  access_wait_timer #(.CW(CW)) u_timer (
    .clk        (clk),
    .rst_n      (nRESET),
    .i_load     (r_state == S_SETUP),
    .i_load_val (WAIT_LOAD),
    .i_dec      ((r_state == S_WAIT) && !w_zero),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_remain <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_addr   <= start_addr;
          r_remain <= length;
          r_busy   <= 1'b1;
          if (length == '0) begin
            r_state <= S_FINISH;
            r_done  <= 1'b1;
          end else if (start_addr > ADDR_LIMIT) begin
            r_state <= S_FINISH;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_state <= S_SETUP;
          end
        end
        S_SETUP: r_state <= S_WAIT;
        S_WAIT: if (w_zero) begin
          r_data  <= flash_data;
          r_valid <= 1'b1;
          r_state <= S_HOLD;
        end
        // Range check on the incremented address happens here, before any
        // SETUP, so an unmapped address is never presented for an access.
        S_HOLD: if (out_ready) begin
          r_valid  <= 1'b0;
          r_remain <= r_remain - LEN_W'(1);
          if (r_remain == LEN_W'(1)) begin
            r_state <= S_FINISH;
            r_done  <= 1'b1;
          end else begin
            r_addr <= w_addr_inc;
            if (w_addr_inc > ADDR_LIMIT) begin
              r_state <= S_FINISH;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state <= S_SETUP;
            end
          end
        end
        S_FINISH: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign address    = r_addr;
  assign busy       = r_busy;
  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign done       = r_done;
  assign range_err  = r_err;
endmodule

// File: tb/tb_flash_read_sequencer.sv
// Directed bench for flash_read_sequencer: expected bytes are queued at
// request time and popped at each valid/ready handshake.
module tb_flash_read_sequencer;
  logic        clk        = 1'b0;
  logic        nRESET     = 1'b1;
  logic        start      = 1'b0;
  logic [15:0] start_addr = '0;
  logic [7:0]  length     = '0;
  logic        out_ready  = 1'b1;
  logic [7:0]  flash_data;
  logic [15:0] address;
  logic [7:0]  data_out;
  logic        busy, data_valid, done, range_err;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] fmodel(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ {2'b00, a[13:8]};
  endfunction

  assign flash_data = fmodel(address);

  flash_read_sequencer #(
    .N(16), .LEN_W(8), .WAIT_CYCLES(3), .ADDR_LIMIT(16'h3FFF)
  ) dut (
    .clk        (clk),
    .nRESET     (nRESET),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .flash_data (flash_data),
    .out_ready  (out_ready),
    .address    (address),
    .busy       (busy),
    .data_out   (data_out),
    .data_valid (data_valid),
    .done       (done),
    .range_err  (range_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic launch(input logic [15:0] a0, input int len);
    logic [15:0] a;
    start_addr = a0;
    length     = 8'(len);
    start      = 1'b1;
    for (int i = 0; i < len; i++) begin
      a = a0 + 16'(i);
      if (a > 16'h3FFF) break;
      sb.push_back({a, fmodel(a)});
    end
  endtask

  // Runs one transfer to its done pulse; optionally stalls out_ready at one
  // byte and/or pokes a second start mid-transfer.
  task automatic collect(input string tag, input int stall_idx, input bit inject,
                         output int lat, output int gap_min, output int ndone,
                         output int nerr, output int bad_addr);
    int          cyc, byte_i, last_hs;
    bit          fin, stalled;
    logic [15:0] sa;
    logic [7:0]  sd;
    exp_t        e;
    cyc = 0; byte_i = 0; last_hs = -1; fin = 0; stalled = 0;
    lat = -1; gap_min = 1000; ndone = 0; nerr = 0; bad_addr = 0;
    while (!fin && cyc < 200) begin
      step();
      cyc++;
      start = 1'b0;
      if (inject && cyc == 2) begin
        start = 1'b1; start_addr = 16'h0200; length = 8'd5;
      end
      if (busy && !done && address > 16'h3FFF) bad_addr++;
      if (data_valid && lat < 0) lat = cyc;
      if (done) begin
        ndone++;
        if (range_err) nerr++;
        fin = 1;
      end else if (data_valid) begin
        if (byte_i == stall_idx && !stalled) begin
          stalled = 1; out_ready = 1'b0; sa = address; sd = data_out;
          repeat (10) begin step(); cyc++; end
          chk({tag, "_stall_addr"}, 32'(address), 32'(sa));
          chk({tag, "_stall_data"}, 32'(data_out), 32'(sd));
          chk({tag, "_stall_valid"}, 32'(data_valid), 32'd1);
          out_ready = 1'b1;
        end
        chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk({tag, "_addr"}, 32'(address), 32'(e.a));
          chk({tag, "_data"}, 32'(data_out), 32'(e.d));
        end
        if (last_hs >= 0 && cyc - last_hs < gap_min) gap_min = cyc - last_hs;
        last_hs = cyc;
        byte_i++;
      end
    end
    chk({tag, "_done_seen"}, 32'(fin), 32'd1);
  endtask

  int lat, gap, nd, ne, bad;

  initial begin
    #2 nRESET = 1'b0;
    #1;
    chk("rst_addr", 32'(address), 32'h0);
    chk("rst_flags", {28'h0, busy, data_valid, done, range_err}, 32'h0);
    chk("rst_data", 32'(data_out), 32'h0);
    repeat (2) @(negedge clk);
    nRESET = 1'b1;
    step();

    launch(16'h0010, 3);
    collect("s1", -1, 0, lat, gap, nd, ne, bad);
    chk("s1_latency", 32'(lat), 32'd5);
    chk("s1_period", 32'(gap), 32'd5);
    chk("s1_done", 32'(nd), 32'd1);
    chk("s1_err", 32'(ne), 32'd0);
    chk("s1_sb_empty", 32'(sb.size()), 32'd0);
    step();
    chk("s1_idle", {30'h0, busy, done}, 32'h0);

    launch(16'h0100, 3);
    collect("s2", 1, 0, lat, gap, nd, ne, bad);
    chk("s2_done", 32'(nd), 32'd1);
    chk("s2_err", 32'(ne), 32'd0);
    chk("s2_sb_empty", 32'(sb.size()), 32'd0);
    step();

    launch(16'h3FFE, 4);
    collect("s3", -1, 0, lat, gap, nd, ne, bad);
    chk("s3_done", 32'(nd), 32'd1);
    chk("s3_err", 32'(ne), 32'd1);
    chk("s3_bad_addr", 32'(bad), 32'd0);
    chk("s3_sb_empty", 32'(sb.size()), 32'd0);
    step();

    launch(16'h4000, 2);
    collect("s4", -1, 0, lat, gap, nd, ne, bad);
    chk("s4_no_valid", 32'(lat), 32'hFFFF_FFFF);
    chk("s4_done", 32'(nd), 32'd1);
    chk("s4_err", 32'(ne), 32'd1);
    step();
    chk("s4_idle", 32'(busy), 32'd0);

    launch(16'h0020, 0);
    collect("s5", -1, 0, lat, gap, nd, ne, bad);
    chk("s5_no_valid", 32'(lat), 32'hFFFF_FFFF);
    chk("s5_done", 32'(nd), 32'd1);
    chk("s5_err", 32'(ne), 32'd0);
    step();

    launch(16'h0300, 2);
    collect("s6", -1, 1, lat, gap, nd, ne, bad);
    chk("s6_done", 32'(nd), 32'd1);
    chk("s6_sb_empty", 32'(sb.size()), 32'd0);
    step();
    chk("s6_idle_a", 32'(busy), 32'd0);
    step();
    chk("s6_idle_b", 32'(busy), 32'd0);

    // Reset lands in the WAIT window of the second byte.
    start_addr = 16'h0010; length = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    nRESET = 1'b0;
    #1;
    chk("s7_rst_addr", 32'(address), 32'h0);
    chk("s7_rst_flags", {28'h0, busy, data_valid, done, range_err}, 32'h0);
    chk("s7_rst_data", 32'(data_out), 32'h0);
    sb.delete();
    repeat (2) @(negedge clk);
    nRESET = 1'b1;
    step();

    launch(16'h0010, 3);
    collect("s8", -1, 0, lat, gap, nd, ne, bad);
    chk("s8_latency", 32'(lat), 32'd5);
    chk("s8_period", 32'(gap), 32'd5);
    chk("s8_done", 32'(nd), 32'd1);
    chk("s8_err", 32'(ne), 32'd0);
    chk("s8_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
